// File: rtl/mask_pkg.sv
// rtl/mask_pkg.sv - shared widths and FSM encoding for the 512b mask blocks
package mask_pkg;

  localparam int MASK_W = 512;
  localparam int IDX_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } mask_state_e;

endpackage

// File: rtl/mask_chunk_penc.sv
// rtl/mask_chunk_penc.sv - first/last set-bit encoder for one scan chunk
module mask_chunk_penc #(
  parameter int CHUNK_W = 32
) (
  input  logic [CHUNK_W-1:0]         chunk,
  output logic                       any,
  output logic [$clog2(CHUNK_W)-1:0] first_off,
  output logic [$clog2(CHUNK_W)-1:0] last_off
);

  localparam int OW = $clog2(CHUNK_W);

  // Offsets count from the chunk MSB, matching the index-0-is-MSB convention.
  always_comb begin
    any       = 1'b0;
    first_off = '0;
    last_off  = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      if (chunk[CHUNK_W-1-i]) begin
        if (!any) first_off = OW'(i);
        last_off = OW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mask_bound_extract_512bit.sv
// rtl/mask_bound_extract_512bit.sv - chunked scan returning left/right bounds of a 512b row mask; MASK_CONTIG_CHECK_EN enables the run-count check
module mask_bound_extract_512bit
  import mask_pkg::*;
#(
  parameter int CHUNK_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_trig,
  input  logic [MASK_W-1:0] i_mask,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_bound_index_left,
  output logic [IDX_W-1:0]  o_bound_index_right,
  output logic              o_empty,
  output logic              o_noncontig
);

  localparam int NCHUNK = MASK_W / CHUNK_W;
  localparam int OW     = $clog2(CHUNK_W);
  localparam logic [IDX_W-1:0] STEP      = IDX_W'(CHUNK_W % MASK_W);
  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(MASK_W - CHUNK_W);

  mask_state_e        state;
  logic               trig_d;
  logic               done_q;
  logic               found_l;
  logic [MASK_W-1:0]  mask_q;
  logic [MASK_W-1:0]  mask_shl;
  logic [IDX_W-1:0]   base_q;
  logic [IDX_W-1:0]   left_w;
  logic [IDX_W-1:0]   right_w;
  logic [CHUNK_W-1:0] chunk;
  logic               chunk_any;
  logic [OW-1:0]      first_off;
  logic [OW-1:0]      last_off;

  // The working copy shifts left each cycle so the current chunk is always at the top.
  assign chunk = mask_q[MASK_W-1 -: CHUNK_W];

  generate
    if (NCHUNK > 1) begin : g_shift
      assign mask_shl = {mask_q[MASK_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
    end else begin : g_noshift
      assign mask_shl = '0;
    end
  endgenerate

  mask_chunk_penc #(.CHUNK_W(CHUNK_W)) u_penc (
    .chunk     (chunk),
    .any       (chunk_any),
    .first_off (first_off),
    .last_off  (last_off)
  );

`ifdef MASK_CONTIG_CHECK_EN
  // Rising-edge count saturates at 2: only "more than one run" matters.
  logic [1:0]         cnt_q;
  logic [1:0]         cnt_next;
  logic               prev_bit;
  logic [CHUNK_W-1:0] rises;

  assign rises = chunk & ~{prev_bit, chunk[CHUNK_W-1:1]};

  always_comb begin
    cnt_next = cnt_q;
    if (rises != '0) begin
      if (((rises & (rises - CHUNK_W'(1))) != '0) || (cnt_q != 2'd0)) cnt_next = 2'd2;
      else                                                              cnt_next = 2'd1;
    end
  end
`else
  assign o_noncontig = 1'b0;
`endif

  assign o_done = done_q & i_trig;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      trig_d              <= 1'b0;
      done_q              <= 1'b0;
      found_l             <= 1'b0;
      mask_q              <= '0;
      base_q              <= '0;
      left_w              <= '0;
      right_w             <= '0;
      o_bound_index_left  <= '0;
      o_bound_index_right <= '0;
      o_empty             <= 1'b0;
`ifdef MASK_CONTIG_CHECK_EN
      cnt_q               <= 2'd0;
      prev_bit            <= 1'b0;
      o_noncontig         <= 1'b0;
`endif
    end else begin
      trig_d <= i_trig;
      case (state)
        IDLE: begin
          if (i_trig && !trig_d) begin
            mask_q  <= i_mask;
            base_q  <= '0;
            found_l <= 1'b0;
            left_w  <= '0;
            right_w <= '0;
`ifdef MASK_CONTIG_CHECK_EN
            cnt_q    <= 2'd0;
            prev_bit <= 1'b0;
`endif
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (!i_trig) begin
            state <= IDLE;
          end else begin
            if (chunk_any) begin
              if (!found_l) begin
                left_w  <= base_q + IDX_W'(first_off);
                found_l <= 1'b1;
              end
              right_w <= base_q + IDX_W'(last_off);
            end
            mask_q <= mask_shl;
            base_q <= base_q + STEP;
`ifdef MASK_CONTIG_CHECK_EN
            cnt_q    <= cnt_next;
            prev_bit <= chunk[0];
`endif
            if (base_q == LAST_BASE) state <= DONE;
          end
        end
        DONE: begin
          if (!i_trig) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end else if (!done_q) begin
            o_bound_index_left  <= left_w;
            o_bound_index_right <= right_w;
            o_empty             <= ~found_l;
`ifdef MASK_CONTIG_CHECK_EN
            o_noncontig         <= (cnt_q == 2'd2);
`endif
            done_q              <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
